// File: rtl/serial_adder.sv
// Bit-serial ripple adder: adds a + b + cin one bit per clock, LSB first,
// with the carry held in a flip-flop between bits. A result takes WIDTH
// cycles in ADD plus one DONE cycle, so back-to-back operations repeat
// every WIDTH+2 cycles.
//
// Optional feature: define SERIAL_ADDER_OVF_EN to compute the signed-overflow
// flag. Without the macro, the ovf port is tied to 0.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             ovf
);

  // A counter width of at least 1 keeps WIDTH=1 legal.
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic [WIDTH-1:0] s_q;
  logic             c_q;
  logic             accept;
  logic             last_bit;
  logic             sum_bit;
  logic             carry_nxt;
  logic [WIDTH:0]   sum_shift;

  // One bit position: two cascaded half adders with their carries ORed.
  // Returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y,
                                          input logic ci);
    logic p, g;
    p = x ^ y;
    g = x & y;
    return {g | (ci & p), p ^ ci};
  endfunction

  assign accept    = (state_q == IDLE) && start;
  assign last_bit  = (cnt_q == CNT_W'(WIDTH - 1));
  assign {carry_nxt, sum_bit} = full_add(a_q[0], b_q[0], carry_q);
  // New sum bit enters at the MSB; after WIDTH shifts sum_q holds the full sum.
  assign sum_shift = {sum_bit, sum_q};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ADD;
      ADD:     if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state: bit counter and the carry flip-flop between bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else if (accept) begin
      cnt_q   <= '0;
      carry_q <= cin;
    end else if (state_q == ADD) begin
      cnt_q   <= cnt_q + 1'b1;
      carry_q <= carry_nxt;
    end
  end

  // Operand and partial-sum shift registers; captured once, so later input
  // changes or ignored start pulses cannot disturb them.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a;
      b_q <= b;
    end else if (state_q == ADD) begin
      a_q   <= a_q >> 1;
      b_q   <= b_q >> 1;
      sum_q <= sum_shift[WIDTH:1];
    end
  end

  // Result registers: loaded only by the edge that processes the MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q <= '0;
      c_q <= 1'b0;
    end else if ((state_q == ADD) && last_bit) begin
      s_q <= sum_shift[WIDTH:1];
      c_q <= carry_nxt;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q;
  logic ovf_nxt;

  // On the MSB edge a_q[0]/b_q[0] are the operand sign bits.
  assign ovf_nxt = (a_q[0] == b_q[0]) && (sum_bit != a_q[0]);

  // Signed-overflow flag, loaded together with the sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if ((state_q == ADD) && last_bit) begin
      ovf_q <= ovf_nxt;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign busy = (state_q == ADD);
  assign done = (state_q == DONE);
  assign s    = s_q;
  assign c    = c_q;

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder (WIDTH=8): directed vectors with literal
// expectations plus a cycle-level reference model compared every cycle.
module tb_serial_adder;
  localparam int W = 8;
`ifdef SERIAL_ADDER_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, start, cin;
  logic [W-1:0] a, b;
  logic         busy, done, c, ovf;
  logic [W-1:0] s;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt = 0;
  int last_done_cyc = 0;
  int prev_done_cyc = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .s(s), .c(c), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: an operation accepted in idle finishes W edges later,
  // then shows done for one cycle; results are plain integer addition.
  bit           m_on = 1'b0;
  int           m_left = 0;
  bit           m_done = 1'b0;
  logic [W-1:0] m_s, p_s;
  logic         m_c, p_c, m_ovf, p_ovf;

  always @(posedge clk) begin
    if (rst) begin
      m_on = 1'b1; m_left = 0; m_done = 1'b0;
      m_s = '0; m_c = 1'b0; m_ovf = 1'b0;
    end else if (m_on) begin
      if (m_done) begin
        m_done = 1'b0;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_s = p_s; m_c = p_c; m_ovf = p_ovf; m_done = 1'b1;
        end
      end else if (start) begin
        {p_c, p_s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        p_ovf = OVF_EN && (a[W-1] == b[W-1]) && (p_s[W-1] != a[W-1]);
        m_left = W;
      end
    end
  end

  // Compare process: every cycle once the model has seen reset.
  always @(negedge clk) begin
    cyc++;
    if (m_on) begin
      chk("busy", {31'b0, busy}, {31'b0, m_left > 0});
      chk("done", {31'b0, done}, {31'b0, m_done});
      chk("s",    {24'b0, s},    {24'b0, m_s});
      chk("c",    {31'b0, c},    {31'b0, m_c});
      chk("ovf",  {31'b0, ovf},  {31'b0, m_ovf});
    end
    if (done === 1'b1) begin
      done_cnt++;
      prev_done_cyc = last_done_cyc;
      last_done_cyc = cyc;
    end
  end

  // Starts one operation at the current negedge, scrambles the inputs after
  // acceptance and waits (bounded) for done. Returns the sampled results.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tc, output logic [W-1:0] rs,
                        output logic rc, output logic rovf,
                        output int lat, output int nbusy);
    start = 1'b1; a = ta; b = tb_v; cin = tc;
    @(negedge clk);
    start = 1'b0; a = ~ta; b = ta ^ tb_v; cin = ~tc;
    lat = 1; nbusy = 0;
    while (done !== 1'b1 && lat < 30) begin
      if (busy === 1'b1) nbusy++;
      @(negedge clk);
      lat++;
    end
    if (lat >= 30) chk("done_timeout", 32'd0, 32'd1);
    rs = s; rc = c; rovf = ovf;
    @(negedge clk);
  endtask

  logic [W-1:0] rs;
  logic         rc, rovf;
  int           lat, nbusy, d0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_s",    {24'b0, s},    32'd0);
    chk("rst_c",    {31'b0, c},    32'd0);
    chk("rst_ovf",  {31'b0, ovf},  32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 0 + 0 + 0: busy 8 cycles, done 8 edges after acceptance.
    run_op(8'h00, 8'h00, 1'b0, rs, rc, rovf, lat, nbusy);
    chk("zero_lat",  lat, 32'd9);
    chk("zero_busy", nbusy, 32'd8);
    chk("zero_s",    {24'b0, rs}, 32'h00);
    chk("zero_c",    {31'b0, rc}, 32'd0);

    run_op(8'hFF, 8'h01, 1'b0, rs, rc, rovf, lat, nbusy);
    chk("ff01_s", {24'b0, rs}, 32'h00);
    chk("ff01_c", {31'b0, rc}, 32'd1);

    run_op(8'hFF, 8'hFF, 1'b1, rs, rc, rovf, lat, nbusy);
    chk("ffff1_s", {24'b0, rs}, 32'hFF);
    chk("ffff1_c", {31'b0, rc}, 32'd1);

    run_op(8'h3C, 8'h5A, 1'b1, rs, rc, rovf, lat, nbusy);
    chk("3c5a1_s", {24'b0, rs}, 32'h97);
    chk("3c5a1_c", {31'b0, rc}, 32'd0);

    // start pulsed during ADD must be ignored.
    #1 d0 = done_cnt;
    start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
    @(negedge clk); start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 30) begin @(negedge clk); lat++; end
    if (lat >= 30) chk("ign_timeout", 32'd0, 32'd1);
    chk("ign_s", {24'b0, s}, 32'h46);
    chk("ign_c", {31'b0, c}, 32'd0);
    repeat (12) @(negedge clk);
    #1 chk("ign_one_done", done_cnt - d0, 32'd1);

    // Reset in the 4th ADD cycle aborts the operation.
    @(negedge clk);
    #1 d0 = done_cnt;
    start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b0;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_s",    {24'b0, s},    32'd0);
    chk("abort_c",    {31'b0, c},    32'd0);
    chk("abort_ovf",  {31'b0, ovf},  32'd0);
    repeat (12) @(negedge clk);
    #1 chk("abort_no_done", done_cnt - d0, 32'd0);
    @(negedge clk);
    run_op(8'hAA, 8'h55, 1'b1, rs, rc, rovf, lat, nbusy);
    chk("after_abort_lat", lat, 32'd9);
    chk("after_abort_s", {24'b0, rs}, 32'h00);
    chk("after_abort_c", {31'b0, rc}, 32'd1);

    // Signed-overflow boundaries.
    run_op(8'h7F, 8'h01, 1'b0, rs, rc, rovf, lat, nbusy);
    chk("7f01_s",   {24'b0, rs},   32'h80);
    chk("7f01_ovf", {31'b0, rovf}, {31'b0, OVF_EN});
    run_op(8'h80, 8'h80, 1'b0, rs, rc, rovf, lat, nbusy);
    chk("8080_s",   {24'b0, rs},   32'h00);
    chk("8080_c",   {31'b0, rc},   32'd1);
    chk("8080_ovf", {31'b0, rovf}, {31'b0, OVF_EN});

    // start held high: a new operation every W+2 cycles with changing operands.
    #1 d0 = done_cnt;
    for (int i = 0; i < 40; i++) begin
      start = 1'b1;
      a = W'(i * 7 + 3); b = W'(i * 13 + 5); cin = i[0];
      @(negedge clk);
    end
    start = 1'b0;
    #1 chk("b2b_done_count", done_cnt - d0, 32'd4);
    chk("b2b_period", last_done_cyc - prev_done_cyc, 32'd10);
    repeat (12) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
